// File: rtl/out_port_fifo.sv
// Multi-channel CPU output port: bus writes are queued per channel and drained
// over valid/ready, with full/stall flags and a sticky overflow flag for dropped writes.
module out_port_fifo #(
    parameter int  WIDTH  = 32,
    parameter int  NUM_CH = 2,
    parameter int  DEPTH  = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [WIDTH-1:0]        bus_contents,
    input  logic                    OutPort_enable,
    input  logic [CH_W-1:0]         ch_sel,
    output logic [NUM_CH*WIDTH-1:0] OutPort_output,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH-1:0]       full,
    output logic                    stall,
    output logic                    overflow,
    input  logic                    overflow_clr
);
    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                SEL_W    = CH_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [SEL_W-1:0]  NUM_CH_L = SEL_W'(NUM_CH);

    logic [WIDTH-1:0] r_mem    [NUM_CH][DEPTH];
    logic [PTR_W-1:0] r_wr_ptr [NUM_CH];
    logic [PTR_W-1:0] r_rd_ptr [NUM_CH];
    logic [CNT_W-1:0] r_cnt    [NUM_CH];
    logic [WIDTH-1:0] r_hold   [NUM_CH];
    logic             r_overflow;

    logic              w_sel_ok;
    logic [NUM_CH-1:0] w_valid;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_pop;
    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0] w_push;
    logic              w_stall;
    logic              w_drop;

    assign w_sel_ok = ({1'b0, ch_sel} < NUM_CH_L);

    // A full channel still accepts a write when its head is popped in the same cycle.
    always_comb begin
        w_valid        = '0;
        w_full         = '0;
        w_pop          = '0;
        w_hit          = '0;
        w_push         = '0;
        OutPort_output = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_valid[k] = (r_cnt[k] != '0);
            w_full[k]  = (r_cnt[k] == FULL_CNT);
            w_pop[k]   = w_valid[k] & out_ready[k];
            w_hit[k]   = OutPort_enable & w_sel_ok & (ch_sel == CH_W'(k));
            w_push[k]  = w_hit[k] & (~w_full[k] | w_pop[k]);
            OutPort_output[k*WIDTH +: WIDTH] = w_valid[k] ? r_mem[k][r_rd_ptr[k]] : r_hold[k];
        end
        w_stall = |(w_hit & w_full & ~w_pop);
        w_drop  = w_stall | (OutPort_enable & ~w_sel_ok);
    end

    assign out_valid = w_valid;
    assign full      = w_full;
    assign stall     = w_stall;
    assign overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_overflow <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_wr_ptr[k] <= '0;
                r_rd_ptr[k] <= '0;
                r_cnt[k]    <= '0;
                r_hold[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_push[k]) begin
                    r_wr_ptr[k] <= r_wr_ptr[k] + PTR_W'(1);
                end
                if (w_pop[k]) begin
                    r_hold[k]   <= r_mem[k][r_rd_ptr[k]];
                    r_rd_ptr[k] <= r_rd_ptr[k] + PTR_W'(1);
                end
                if (w_push[k] & ~w_pop[k]) begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                end else if (w_pop[k] & ~w_push[k]) begin
                    r_cnt[k] <= r_cnt[k] - CNT_W'(1);
                end
            end
            // A drop in the same cycle as a clear request leaves the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (!clr && w_push[k]) begin
                r_mem[k][r_wr_ptr[k]] <= bus_contents;
            end
        end
    end

endmodule

// File: doc/out_port_fifo.md
Name: out_port_fifo

Overview:
Parametrised successor to the single-register CPU output port. Captures bus words on OutPort_enable into one of NUM_CH independent FIFO channels. Each channel drains to external logic over a valid/ready handshake. Provides full/stall flags so the control unit can hold an `out` instruction, and a sticky overflow flag for dropped writes.

Parameters:
WIDTH, 32, data width of bus_contents and each output channel
NUM_CH, 2, number of output channels (1..16)
DEPTH, 4, entries per channel FIFO; power of two, >=2
CH_W (local), max(1, clog2(NUM_CH)), channel-select width
CNT_W (local), clog2(DEPTH)+1, occupancy counter width

Ports:
clk  input  1  system clock, all state updates on rising edge
clr  input  1  synchronous active-high reset
bus_contents  input  WIDTH  CPU bus value to be written
OutPort_enable  input  1  write strobe, sampled on rising clk
ch_sel  input  CH_W  target channel for the write
OutPort_output  output  NUM_CH*WIDTH  channel k data at [k*WIDTH +: WIDTH]
out_valid  output  NUM_CH  channel k has data (count_k != 0)
out_ready  input  NUM_CH  external consumer accepts channel k head
full  output  NUM_CH  channel k count == DEPTH
stall  output  1  combinational: OutPort_enable & selected channel full & no pop on it this cycle
overflow  output  1  sticky: a write was dropped
overflow_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset: clk is the only clock; clr is synchronous and active-high.
- Reset values: on clr at a rising edge, all pointers, counts and hold registers go to 0. overflow=0, out_valid=0, full=0, and OutPort_output is all zeros.
- clr priority: clr beats push, pop and overflow_clr in the same cycle. clr mid-operation discards all queued words.
- Per-channel state: mem[DEPTH], wr_ptr and rd_ptr (clog2(DEPTH) bits, wrap modulo DEPTH), count (CNT_W bits), hold register.
- Push condition: OutPort_enable=1, ch_sel<NUM_CH, and (count<DEPTH or pop on the same channel this cycle).
  - Effect: mem[wr_ptr]<=bus_contents; wr_ptr++.
- Pop condition: out_valid[k] & out_ready[k] at the rising edge.
  - Effect: hold_k<=mem[rd_ptr]; rd_ptr++.
- Count update: +1 on push only, -1 on pop only, unchanged on push+pop or idle.
- Simultaneous push+pop, same channel: legal when empty is impossible (valid=0 means no pop). Legal when full: count stays DEPTH and no overflow.
- Dropped write: OutPort_enable=1 with selected channel full and no same-cycle pop. No state change in that channel; overflow<=1.
- Invalid channel: OutPort_enable=1 with ch_sel>=NUM_CH. Write ignored; overflow<=1.
- overflow_clr: clears overflow. If a drop occurs in the same cycle, set wins (overflow stays 1).
- Output data: OutPort_output_k = mem[rd_ptr] when count_k!=0, else hold_k (last popped word). This preserves the latch semantics of the original port.
- Latency: word pushed at edge N is visible with out_valid=1 after edge N (registered, first-word fall-through). No combinational path from bus_contents to OutPort_output.
- Channel independence: channels never interact except through the shared overflow flag.
- Consumer rule: out_ready may be held high permanently; when empty no pop occurs.
- Width rules: data passes unmodified. No sign or zero extension.

Test Plan:
1. Reset and single word: clr 2 cycles, then write 0x00000008 to ch0 (one enable cycle), out_ready=0. Expect out_valid=2'b01 and OutPort_output[31:0]=0x00000008 one edge later. Pulse out_ready[0]: out_valid[0]->0 and data holds 0x00000008.
2. Fill and overflow: out_ready=0, write 0x11,0x22,0x33,0x44 to ch1. Expect full[1]=1. A 5th write of 0x55 asserts stall during that cycle, then overflow=1. Drain yields 0x11,0x22,0x33,0x44, never 0x55.
3. Full push+pop: ch0 full with A..D, out_ready[0]=1 and write 0xE in the same cycle. Expect count stays 4, overflow=0, and the drain order B,C,D,E.
4. Invalid channel and sticky clear: NUM_CH=3, ch_sel=3 with enable. Expect no channel change and overflow=1. overflow_clr plus a simultaneous dropped write keeps overflow=1; overflow_clr alone clears it.
5. Reset mid-operation: ch0 holds 3 words, then assert clr with OutPort_enable=1 in the same cycle. Expect all counts 0, out_valid=0, OutPort_output=0, and nothing written.
6. Backpressure independence: ch0 out_ready=0, ch1 out_ready=1, alternating writes. ch1 drains each word one cycle after it is written; ch0 accumulates to full without affecting ch1.
